icache_axi_rd_bridge: RTL

- Read-only bridge between the I-cache miss interface (rd_req/rd_addr/ret_*) and an AXI4 read master port (AR/R channels).
- Turns each cache read request into one AXI transaction and returns the read data to the cache beat by beat.
- Downstream of the I-cache, upstream of the system AXI crossbar.
- A 16 B line fill is a 2-beat INCR burst of 8 B; the first beat returned is the low doubleword [63:0].

---
 rtl/icache_axi_rd_bridge.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/icache_axi_rd_bridge.sv
// ---------------------------------------------------------------------------
// icache_axi_rd_bridge
// Read-only bridge from the I-cache miss interface to an AXI4 read master.
// Each cache request becomes exactly one AXI read transaction. The read data
// is handed back to the cache one beat at a time. Only one transaction is
// outstanding at a time.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   rd_req/rd_type/rd_addr   cache request (pulse), access type, byte address
//   rd_rdy                   bridge idle, can take rd_req this cycle
//   ret_valid/ret_last       registered return strobe / last beat of request
//   ret_data                 returned 64-bit read data
//   bus_err                  sticky: bad rresp, rid mismatch or rlast mismatch
//   ar*                      AXI AR channel (master side)
//   r*                       AXI R channel (master side)
// ---------------------------------------------------------------------------
module icache_axi_rd_bridge #(
   parameter logic [3:0] AXI_ID     = 4'd0,
   parameter int         LINE_BEATS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_req,
   input  logic [2:0]  rd_type,
   input  logic [31:0] rd_addr,
   output logic        rd_rdy,
   output logic        ret_valid,
   output logic        ret_last,
   output logic [63:0] ret_data,
   output logic        bus_err,
   output logic        arvalid,
   input  logic        arready,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [3:0]  arid,
   input  logic        rvalid,
   output logic        rready,
   input  logic [63:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic [3:0]  rid
);

   localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_AR   = 3'b010,
      S_R    = 3'b100
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] beat_cnt;
   logic       ar_hs;
   logic       r_hs;
   logic       last_beat;

   assign ar_hs     = arvalid & arready;
   assign r_hs      = rvalid & rready;
   // Completion is decided by the beat count, never by rlast, so a
   // malformed rlast cannot leave the cache waiting forever.
   assign last_beat = (beat_cnt == arlen);
   assign arburst   = 2'b01;
   assign arid      = AXI_ID;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values present before the edge.
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default assignment first, so no path leaves state_nxt
      // unassigned and no latch is inferred.
      state_nxt = state;
      case (state)
         S_IDLE:  if (rd_req)               state_nxt = S_AR;
         S_AR:    if (arready)              state_nxt = S_R;
         S_R:     if (rvalid && last_beat)  state_nxt = S_IDLE;
         default:                           state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded straight from the one-hot state bits. arvalid is high
   // exactly in AR, and rready exactly in R.
   always_comb begin
      rd_rdy  = (state == S_IDLE);
      arvalid = (state == S_AR);
      rready  = (state == S_R);
   end

   // Request capture. The registers hold still through AR, so the address
   // phase is stable until arready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         araddr <= '0;
         arlen  <= '0;
         arsize <= '0;
      end else if (rd_rdy && rd_req) begin
         if (rd_type == 3'b100) begin
            araddr <= {rd_addr[31:4], 4'b0000};
            arlen  <= LINE_LEN;
            arsize <= 3'b011;
         end else if (rd_type[2]) begin
            // Reserved types 101..111 fall back to a single dword read.
            araddr <= rd_addr;
            arlen  <= 8'd0;
            arsize <= 3'b011;
         end else begin
            araddr <= rd_addr;
            arlen  <= 8'd0;
            arsize <= {1'b0, rd_type[1:0]};
         end
      end
   end

   // Beat counting, the registered return path and sticky error detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt  <= '0;
         ret_valid <= 1'b0;
         ret_last  <= 1'b0;
         ret_data  <= '0;
         bus_err   <= 1'b0;
      end else begin
         ret_valid <= r_hs;
         ret_last  <= r_hs && last_beat;
         if (ar_hs)     beat_cnt <= '0;
         else if (r_hs) beat_cnt <= beat_cnt + 8'd1;
         if (r_hs) begin
            ret_data <= rdata;
            if (rresp != 2'b00 || rid != AXI_ID || rlast != last_beat)
               bus_err <= 1'b1;
         end
      end
   end

endmodule
